// File: rtl/alu_amm_arbiter.sv
// Round-robin arbiter sharing one AMM read slave between NUM_REQ ALU masters,
// with a stall watchdog that aborts hung reads and returns DECODEERROR.
module alu_amm_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_read,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
   output logic [NUM_REQ-1:0]              req_waitrequest,
   output logic [DATA_WIDTH-1:0]           req_readdata,
   output logic [1:0]                      req_response,
   output logic                            m_read,
   output logic [ADDR_WIDTH-1:0]           m_address,
   input  logic [DATA_WIDTH-1:0]           m_readdata,
   input  logic                            m_waitrequest,
   input  logic [1:0]                      m_response,
   output logic [NUM_REQ-1:0]              grant
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = 8;
   // Counter value on the last permitted stall cycle; unused when TIMEOUT is 0.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_REQ - 1);
   localparam logic [1:0]       RESP_DECERR  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [CNT_W-1:0]       stall_q, stall_d;

   logic [ADDR_WIDTH-1:0]  req_addr_arr [NUM_REQ];
   logic                   sel_found;
   logic [IDX_W-1:0]       sel_idx;
   logic [IDX_W-1:0]       owner_next;
   logic                   timeout_hit;

   // Split the flat address bus into one entry per requester.
   for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
      assign req_addr_arr[k] = req_address[k*ADDR_WIDTH +: ADDR_WIDTH];
   end

   // First pending request at or above ptr, wrapping around.
   always_comb begin
      int unsigned cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = int'(ptr_q) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!sel_found && req_read[IDX_W'(cand)]) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(cand);
         end
      end
   end

   assign owner_next  = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
   assign timeout_hit = (TIMEOUT != 0) && (stall_q == TIMEOUT_LAST);

   // State, pointer, owner, address and stall counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         addr_q  <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         addr_q  <= addr_d;
         stall_q <= stall_d;
      end
   end

   // Next-state and output decode; data/response pass through only on completion.
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      owner_d         = owner_q;
      addr_d          = addr_q;
      stall_d         = stall_q;
      m_read          = 1'b0;
      m_address       = '0;
      grant           = '0;
      req_waitrequest = '1;
      req_readdata    = '0;
      req_response    = 2'b00;

      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d = S_BUSY;
               owner_d = sel_idx;
               addr_d  = req_addr_arr[sel_idx];
               stall_d = '0;
            end
         end

         S_BUSY: begin
            m_read                   = 1'b1;
            m_address                = addr_q;
            grant[owner_q]           = 1'b1;
            req_waitrequest[owner_q] = m_waitrequest;
            if (!m_waitrequest) begin
               req_readdata = m_readdata;
               req_response = m_response;
               state_d      = S_IDLE;
               ptr_d        = owner_next;
               stall_d      = '0;
            end else if (!req_read[owner_q]) begin
               // Owner abandoned the read: release the slave without a completion.
               state_d = S_IDLE;
               ptr_d   = owner_next;
               stall_d = '0;
            end else begin
               stall_d = stall_q + CNT_W'(1);
               if (timeout_hit) state_d = S_ABORT;
            end
         end

         S_ABORT: begin
            m_address                = addr_q;
            grant[owner_q]           = 1'b1;
            req_waitrequest[owner_q] = 1'b0;
            req_response             = RESP_DECERR;
            state_d                  = S_IDLE;
            ptr_d                    = owner_next;
            stall_d                  = '0;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
